// File: rtl/light_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : light_sequencer_if
// Brief    : User-control / LED-driver bundle for light_sequencer.
// Revision : 1.0
// ============================================================================
interface light_sequencer_if #(
  parameter int CH_W = 8
);
  logic              sel;
  logic [1:0]        mode;
  logic              button;
  logic [CH_W-1:0]   level;
  logic [3*CH_W-1:0] light;
  logic [2:0]        idx;
  logic              step;

  modport master (
    output sel, mode, button, level,
    input  light, idx, step
  );

  modport slave (
    input  sel, mode, button, level,
    output light, idx, step
  );
endinterface
`default_nettype wire

// File: rtl/light_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : light_sequencer
// Brief    : Steps through the six saturated RGB colours in hold/manual/auto/
//            bounce modes and drives a registered, level-scaled RGB output.
// Revision : 1.0
// ============================================================================
module light_sequencer #(
  parameter int CH_W = 8,
  parameter int DIV  = 4
) (
  input  logic               clk,
  input  logic               rst,
  light_sequencer_if.slave   bus
);
  localparam int               CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DIV - 1);

  localparam logic [1:0] C_MODE_HOLD   = 2'b00;
  localparam logic [1:0] C_MODE_MANUAL = 2'b01;
  localparam logic [1:0] C_MODE_AUTO   = 2'b10;
  localparam logic [1:0] C_MODE_BOUNCE = 2'b11;

  typedef enum logic [0:0] {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [2:0]        idx_q,   idx_d;
  dir_e              dir_q,   dir_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [3*CH_W-1:0] light_q, light_d;
  logic              step_q,  step_d;
  logic              btn_q;
  logic [1:0]        mode_q;

  logic [2:0] idx_up;
  logic       rise;
  logic       mode_chg;
  logic       idx_ok;
  logic       adv;

  // mode_q loads the live mode during reset so leaving reset is not seen as a mode change
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= 3'd1;
      dir_q   <= DIR_UP;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      mode_q  <= bus.mode;
      light_q <= '0;
      step_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      btn_q   <= bus.button;
      mode_q  <= bus.mode;
      light_q <= light_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    idx_up   = (idx_q == 3'd6) ? 3'd1 : idx_q + 3'd1;
    rise     = bus.button & ~btn_q;
    mode_chg = (bus.mode != mode_q);
    idx_ok   = (idx_q != 3'd0) && (idx_q != 3'd7);
    adv      = 1'b0;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    dir_d    = (bus.mode == C_MODE_BOUNCE) ? dir_q : DIR_UP;

    if (!idx_ok) begin
      idx_d = 3'd1;
      cnt_d = '0;
    end else if (mode_chg) begin
      cnt_d = '0;
    end else begin
      case (bus.mode)
        C_MODE_HOLD: begin
          cnt_d = '0;
        end
        C_MODE_MANUAL: begin
          cnt_d = '0;
          if (rise) idx_d = idx_up;
        end
        default: begin
          if (!bus.button) begin
            cnt_d = '0;
          end else if (cnt_q == C_CNT_LAST) begin
            cnt_d = '0;
            adv   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end

    if (adv) begin
      if (bus.mode == C_MODE_AUTO) begin
        idx_d = idx_up;
      end else if (dir_q == DIR_UP) begin
        if (idx_q == 3'd6) begin
          idx_d = 3'd5;
          dir_d = DIR_DOWN;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        if (idx_q == 3'd1) begin
          idx_d = 3'd2;
          dir_d = DIR_UP;
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end
    end

    step_d = (idx_d != idx_q);

    // colour is taken from the pre-update index, so it trails idx by one edge
    if (bus.sel) begin
      light_d = {idx_q[2] ? bus.level : {CH_W{1'b0}},
                 idx_q[1] ? bus.level : {CH_W{1'b0}},
                 idx_q[0] ? bus.level : {CH_W{1'b0}}};
    end else begin
      light_d = {3{bus.level}};
    end
  end

  assign bus.light = light_q;
  assign bus.idx   = idx_q;
  assign bus.step  = step_q;

endmodule
`default_nettype wire

// File: tb/tb_light_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_light_sequencer
// Brief    : Directed self-checking bench; DIV=4 and DIV=1 instances share stimulus.
// Revision : 1.0
// ============================================================================
module tb_light_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  light_sequencer_if #(.CH_W(8)) if4 ();
  light_sequencer_if #(.CH_W(8)) if1 ();

  light_sequencer #(.CH_W(8), .DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  light_sequencer #(.CH_W(8), .DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  typedef struct {
    logic        r;
    logic        s;
    logic [1:0]  m;
    logic        b;
    logic [7:0]  lv;
    logic [23:0] el;
    logic [2:0]  ei;
    logic        es;
  } vec_t;

  vec_t vecs [19];

  task automatic drive(input logic r, input logic s, input logic [1:0] m,
                       input logic b, input logic [7:0] lv);
    rst        = r;
    if4.sel    = s;  if1.sel    = s;
    if4.mode   = m;  if1.mode   = m;
    if4.button = b;  if1.button = b;
    if4.level  = lv; if1.level  = lv;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [23:0] col(input logic [2:0] i, input logic [7:0] lv);
    return {i[2] ? lv : 8'h00, i[1] ? lv : 8'h00, i[0] ? lv : 8'h00};
  endfunction

  int bexp [17] = '{2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 2, 3, 4, 5, 6, 5, 4};

  initial begin
    // reset, white path with manual toggling, then manual stepping from idx 1
    vecs[0]  = '{1'b1, 1'b1, 2'b00, 1'b0, 8'hFF, 24'h000000, 3'd1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 2'b00, 1'b0, 8'hFF, 24'h000000, 3'd1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 2'b00, 1'b0, 8'hFF, 24'h000000, 3'd1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 2'b00, 1'b0, 8'hFF, 24'h0000FF, 3'd1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'b00, 1'b0, 8'hFF, 24'hFFFFFF, 3'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 2'b00, 1'b0, 8'h80, 24'h808080, 3'd1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 2'b01, 1'b0, 8'h80, 24'h808080, 3'd1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'b01, 1'b1, 8'h80, 24'h808080, 3'd2, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 2'b01, 1'b0, 8'h80, 24'h808080, 3'd2, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'b01, 1'b1, 8'h80, 24'h808080, 3'd3, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 2'b01, 1'b0, 8'h80, 24'h808080, 3'd3, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 2'b01, 1'b0, 8'hFF, 24'h000000, 3'd1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 2'b01, 1'b0, 8'hFF, 24'h0000FF, 3'd1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 2'b01, 1'b1, 8'hFF, 24'h0000FF, 3'd2, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 2'b01, 1'b0, 8'hFF, 24'h00FF00, 3'd2, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 2'b01, 1'b1, 8'hFF, 24'h00FF00, 3'd3, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 2'b01, 1'b0, 8'hFF, 24'h00FFFF, 3'd3, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 2'b01, 1'b1, 8'hFF, 24'h00FFFF, 3'd4, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 2'b01, 1'b0, 8'hFF, 24'hFF0000, 3'd4, 1'b0};

    drive(1'b1, 1'b1, 2'b00, 1'b0, 8'hFF);
    for (int v = 0; v < 19; v++) begin
      drive(vecs[v].r, vecs[v].s, vecs[v].m, vecs[v].b, vecs[v].lv);
      tick();
      chk($sformatf("vec%0d_light", v), if4.light, vecs[v].el);
      chk($sformatf("vec%0d_idx", v), {21'd0, if4.idx}, {21'd0, vecs[v].ei});
      chk($sformatf("vec%0d_step", v), {23'd0, if4.step}, {23'd0, vecs[v].es});
    end

    // MANUAL: button held 10 clocks gives exactly one step
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 2'b01, 1'b1, 8'hFF);
      tick();
      chk($sformatf("hold%0d_idx", i), {21'd0, if4.idx}, 24'd5);
      chk($sformatf("hold%0d_step", i), {23'd0, if4.step}, (i == 0) ? 24'd1 : 24'd0);
      chk($sformatf("hold%0d_light", i), if4.light, (i == 0) ? 24'hFF0000 : 24'hFF00FF);
    end

    // AUTO, DIV=4: 24 clocks of button wrap idx back to 1
    drive(1'b1, 1'b1, 2'b10, 1'b0, 8'hFF);
    tick();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 8'hFF);
    tick();
    chk("auto_start_light", if4.light, 24'h0000FF);
    for (int k = 1; k <= 24; k++) begin
      drive(1'b0, 1'b1, 2'b10, 1'b1, 8'hFF);
      tick();
      chk($sformatf("auto%0d_idx", k), {21'd0, if4.idx}, 24'(((k / 4) % 6) + 1));
      chk($sformatf("auto%0d_step", k), {23'd0, if4.step}, (k % 4 == 0) ? 24'd1 : 24'd0);
      chk($sformatf("auto%0d_light", k), if4.light, col(3'(((k - 1) / 4) % 6 + 1), 8'hFF));
    end
    // drop at div_cnt=2, then re-raise: the count restarts from zero
    tick();
    tick();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 8'hFF);
    tick();
    chk("drop_idx", {21'd0, if4.idx}, 24'd1);
    drive(1'b0, 1'b1, 2'b10, 1'b1, 8'hFF);
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk($sformatf("reraise%0d_idx", j), {21'd0, if4.idx}, (j == 4) ? 24'd2 : 24'd1);
      chk($sformatf("reraise%0d_step", j), {23'd0, if4.step}, (j == 4) ? 24'd1 : 24'd0);
    end

    // BOUNCE on the DIV=1 instance
    drive(1'b1, 1'b1, 2'b11, 1'b0, 8'hFF);
    tick();
    drive(1'b0, 1'b1, 2'b11, 1'b0, 8'hFF);
    tick();
    chk("bounce_start_idx", {21'd0, if1.idx}, 24'd1);
    drive(1'b0, 1'b1, 2'b11, 1'b1, 8'hFF);
    for (int i = 0; i < 17; i++) begin
      tick();
      chk($sformatf("bounce%0d_idx", i), {21'd0, if1.idx}, 24'(bexp[i]));
      chk($sformatf("bounce%0d_step", i), {23'd0, if1.step}, 24'd1);
    end
    // descending at 4, switch to AUTO: mode-change cycle has no step, then up to 5
    drive(1'b0, 1'b1, 2'b10, 1'b1, 8'hFF);
    tick();
    chk("modechg_idx", {21'd0, if1.idx}, 24'd4);
    chk("modechg_step", {23'd0, if1.step}, 24'd0);
    tick();
    chk("dirup_idx", {21'd0, if1.idx}, 24'd5);
    chk("dirup_step", {23'd0, if1.step}, 24'd1);

    // mid-operation reset from AUTO at idx 5, then HOLD with button high
    drive(1'b1, 1'b1, 2'b10, 1'b0, 8'hFF);
    tick();
    drive(1'b0, 1'b1, 2'b10, 1'b1, 8'hFF);
    for (int i = 0; i < 16; i++) tick();
    chk("pre_rst_idx", {21'd0, if4.idx}, 24'd5);
    drive(1'b1, 1'b1, 2'b10, 1'b1, 8'hFF);
    tick();
    chk("midrst_idx", {21'd0, if4.idx}, 24'd1);
    chk("midrst_light", if4.light, 24'h000000);
    chk("midrst_step", {23'd0, if4.step}, 24'd0);
    drive(1'b0, 1'b1, 2'b00, 1'b1, 8'hFF);
    tick();
    chk("postrst_light", if4.light, 24'h0000FF);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("hold_mode%0d_idx", i), {21'd0, if4.idx}, 24'd1);
      chk($sformatf("hold_mode%0d_step", i), {23'd0, if4.step}, 24'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
